rom_sample_streamer: RTL and testbench

ROM_SAMPLE_STREAMER -- requirements
Module: rom_sample_streamer

---
 rtl/rom_sample_streamer.sv | 230 +++++++++++++++++++++++
 tb/tb_rom_sample_streamer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sample_streamer.sv
// ---------------------------------------------------------------------------
// rom_sample_streamer
//
// Purpose:
//   Plays a waveform table held in an external ROM out as a ready/valid
//   sample stream. A run is started with a single-cycle start pulse and
//   plays a programmable number of frames (or runs continuously). One frame
//   is 2^ADDR_WIDTH samples. Within a frame the ROM is walked with a
//   programmable phase increment, so a step of N plays every Nth entry,
//   wrapping around the table. Each frame restarts at address 0.
//
//   ROM reads are issued from a phase accumulator, the returned words are
//   buffered in a 2-entry FIFO together with an end-of-frame tag, and the
//   FIFO head drives the output stream. At most two samples are ever
//   outstanding (buffered plus in flight), which is exactly what the FIFO
//   can absorb when the downstream stalls.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   pulse, begins a run (honoured in IDLE only)
//   stop         in   pulse, ends a run early (honoured in RUN only)
//   frames       in   frames per run, sampled on start; 0 = continuous
//   step         in   phase increment per sample, sampled on start; 0 -> 1
//   rom_addr     out  registered ROM read address
//   rom_rd_data  in   ROM word, valid one cycle after rom_addr changes
//   m_data       out  output sample (FIFO head)
//   m_valid      out  output sample valid (FIFO not empty)
//   m_ready      in   downstream accept
//   m_last       out  last sample of a frame
//   busy         out  high in RUN and DRAIN
//   done         out  one-cycle pulse on the DRAIN->IDLE transition
// ---------------------------------------------------------------------------
module rom_sample_streamer #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [FRAME_CNT_W-1:0] frames,
    input  logic [ADDR_WIDTH-1:0]  step,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_rd_data,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]  LAST_SAMPLE = '1;
    localparam logic [ADDR_WIDTH-1:0]  ONE_STEP    = ADDR_WIDTH'(1);
    localparam logic [FRAME_CNT_W-1:0] ONE_FRAME   = FRAME_CNT_W'(1);

    state_t state;
    state_t state_next;

    // Run control
    logic [ADDR_WIDTH-1:0]  phase;
    logic [ADDR_WIDTH-1:0]  sample_cnt;
    logic [ADDR_WIDTH-1:0]  step_q;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    // Read pipeline
    logic in_flight;
    logic in_flight_last;

    // 2-entry FIFO of {last, data}
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    // Handshake / issue decode
    logic       push;
    logic       pop;
    logic [2:0] committed;
    logic       room;
    logic       frame_end;
    logic       final_issue;
    logic       issue;

    // Decide whether a ROM read may be issued this cycle. The space check
    // counts the FIFO as it will be after this edge (a pop frees a slot in
    // the same cycle), which is what lets a continuously-ready consumer get
    // one sample per cycle while never exceeding two outstanding samples.
    // A stop pulse blocks new issues, except the final read of the final
    // frame, which still goes out.
    always_comb begin
        push        = in_flight;
        pop         = m_valid && m_ready;
        committed   = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
        room        = committed < 3'd2;
        frame_end   = (sample_cnt == LAST_SAMPLE);
        final_issue = frame_end && (frame_cnt == ONE_FRAME);
        issue       = (state == RUN) && room && (!stop || final_issue);
    end

    // Next-state logic and the status outputs. done is decoded from the
    // same condition that moves DRAIN back to IDLE, so it is high for
    // exactly the one cycle before the transition edge.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if ((issue && final_issue) || stop) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((count == 2'd0) && !in_flight) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase accumulator, sample/frame counters and ROM address. A start in
    // IDLE loads the run parameters; each issued read presents the current
    // phase to the ROM and advances the counters. The read of the last
    // sample of a frame snaps the phase back to 0 and, for a finite run,
    // consumes one frame (a zero frame count means continuous and is never
    // decremented).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= '0;
            sample_cnt <= '0;
            step_q     <= '0;
            frame_cnt  <= '0;
            rom_addr   <= '0;
        end else if ((state == IDLE) && start) begin
            phase      <= '0;
            sample_cnt <= '0;
            frame_cnt  <= frames;
            step_q     <= (step == '0) ? ONE_STEP : step;
        end else if (issue) begin
            rom_addr   <= phase;
            sample_cnt <= sample_cnt + ONE_STEP;
            if (frame_end) begin
                phase <= '0;
                if (frame_cnt != '0) begin
                    frame_cnt <= frame_cnt - ONE_FRAME;
                end
            end else begin
                phase <= phase + step_q;
            end
        end
    end

    // In-flight flag: the ROM word for a read issued on this edge arrives
    // during the next cycle and is captured on the following edge. The
    // last-of-frame tag travels alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            in_flight      <= issue;
            in_flight_last <= issue && frame_end;
        end
    end

    // Output FIFO. Writes come from the in-flight read, pops from a
    // completed transfer; both in one cycle leave the occupancy unchanged.
    // Storage is cleared on reset so m_data reads 0 while rst is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rom_rd_data;
                fifo_last[wr_ptr] <= in_flight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The stream is the FIFO head; m_last is qualified by m_valid so a
    // stale tag in an empty slot never shows.
    always_comb begin
        m_valid = (count != 2'd0);
        m_data  = fifo_data[rd_ptr];
        m_last  = m_valid && fifo_last[rd_ptr];
    end

endmodule

// File: tb/tb_rom_sample_streamer.sv
// ---------------------------------------------------------------------------
// tb_rom_sample_streamer
//
// Self-checking bench for rom_sample_streamer. A triangle-wave ROM answers
// reads combinationally from rom_addr, so each word is ready for capture on
// the edge after the address was registered. Expected streams are built up
// front from the frame/step rules (sample n of a run reads address
// ((n mod 128) * step) mod 128, last when n mod 128 == 127) and every
// accepted sample is compared against that list.
// ---------------------------------------------------------------------------
module tb_rom_sample_streamer;

    localparam int AW        = 7;
    localparam int DW        = 8;
    localparam int FW        = 8;
    localparam int FRAME_LEN = 1 << AW;
    localparam int BUDGET    = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [FW-1:0] frames;
    logic [AW-1:0] step;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rom [FRAME_LEN];

    int checks   = 0;
    int failures = 0;

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Asynchronous-read ROM model.
    assign rom_rd_data = rom[rom_addr];

    rom_sample_streamer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FRAME_CNT_W(FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .frames     (frames),
        .step       (step),
        .rom_addr   (rom_addr),
        .rom_rd_data(rom_rd_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Presents the run parameters with a start pulse for the next edge.
    task automatic applyStimulus(input int fr, input int st);
        @(negedge clk);
        frames = FW'(fr);
        step   = AW'(st);
        start  = 1'b1;
    endtask

    // Runs one stream and checks it. rnd randomises m_ready; stopAfter > 0
    // pulses stop once that many issue edges have passed (one issue per
    // cycle under continuous ready); resetAt > 0 asserts rst once that many
    // samples have been accepted and leaves rst high on return.
    task automatic runStream(input int fr, input int st, input bit rnd,
                             input int stopAfter, input int resetAt);
        int      expAddr[$];
        logic    expLast[$];
        int      nExp;
        int      stEff;
        int      got;
        int      firstValid;
        int      lastXferK;
        int      maxOut;
        int      outNow;
        bit      finished;
        bit      holdPrev;
        logic [DW-1:0] prevData;
        logic    prevLast;

        stEff = ((st % FRAME_LEN) == 0) ? 1 : st;
        nExp  = (fr == 0) ? stopAfter : fr * FRAME_LEN;
        for (int n = 0; n < nExp; n++) begin
            int off;
            off = n % FRAME_LEN;
            expAddr.push_back((off * stEff) % FRAME_LEN);
            expLast.push_back(off == FRAME_LEN - 1);
        end

        got        = 0;
        firstValid = -1;
        lastXferK  = -1;
        maxOut     = 0;
        finished   = 1'b0;
        holdPrev   = 1'b0;
        prevData   = '0;
        prevLast   = 1'b0;

        applyStimulus(fr, st);
        m_ready = 1'b1;

        // k counts rising edges since the edge that sampled start.
        for (int k = 0; k < BUDGET && !finished; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = (stopAfter > 0) && (k == stopAfter);
            if (k == 0) begin
                checkOutput("busy_after_start", busy, 1);
            end
            if (resetAt > 0 && got == resetAt) begin
                m_ready = 1'b0;
                rst     = 1'b1;
                #1;
                checkOutput("rst_m_valid", m_valid, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_m_data", m_data, 0);
                checkOutput("rst_rom_addr", rom_addr, 0);
                checkOutput("rst_m_last", m_last, 0);
                finished = 1'b1;
            end else if (done) begin
                checkOutput("done_timing", k, lastXferK + 1);
                checkOutput("busy_with_done", busy, 1);
                finished = 1'b1;
            end else begin
                if (holdPrev) begin
                    checkOutput("hold_valid", m_valid, 1);
                    checkOutput("hold_data", m_data, prevData);
                    checkOutput("hold_last", m_last, prevLast);
                end
                if (m_valid && firstValid < 0) begin
                    firstValid = k;
                end
                if (!rnd && k >= 1 && k <= nExp) begin
                    checkOutput("rom_addr", rom_addr, expAddr[k-1]);
                end
                if (rnd && k >= 1 && fr == 1 && stEff == 1) begin
                    outNow = int'(rom_addr) + 1 - got;
                    if (outNow > maxOut) maxOut = outNow;
                end
                m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_valid && m_ready) begin
                    if (got < nExp) begin
                        checkOutput("m_data", m_data, rom[expAddr[got]]);
                        checkOutput("m_last", m_last, expLast[got]);
                    end else begin
                        checkOutput("extra_sample", got, nExp);
                    end
                    got++;
                    lastXferK = k;
                end
                holdPrev = m_valid && !m_ready;
                prevData = m_data;
                prevLast = m_last;
            end
        end
        stop = 1'b0;
        checkOutput("run_finished", finished, 1);

        if (resetAt == 0) begin
            checkOutput("sample_count", got, nExp);
            if (!rnd) begin
                checkOutput("first_valid_latency", firstValid, 2);
            end
            if (rnd && fr == 1 && stEff == 1) begin
                checkOutput("max_outstanding_le2", maxOut <= 2, 1);
            end
            @(negedge clk);
            checkOutput("busy_after_done", busy, 0);
            checkOutput("done_one_cycle", done, 0);
        end
    endtask

    // Main sequence: reset state, then each scenario in turn.
    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        m_ready = 1'b0;
        frames  = '0;
        step    = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            rom[i] = (i < FRAME_LEN / 2) ? DW'(4 * i) : DW'(4 * (FRAME_LEN - 1 - i));
        end

        repeat (3) @(negedge clk);
        checkOutput("reset_rom_addr", rom_addr, 0);
        checkOutput("reset_m_data", m_data, 0);
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_m_last", m_last, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        rst = 1'b0;

        // A stop pulse in IDLE must not start anything.
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        checkOutput("stop_in_idle_busy", busy, 0);

        $display("[TB] single frame, step 1");
        runStream(1, 1, 1'b0, 0, 0);

        $display("[TB] two frames, step 3");
        runStream(2, 3, 1'b0, 0, 0);

        $display("[TB] single frame, random backpressure");
        runStream(1, 1, 1'b1, 0, 0);

        $display("[TB] continuous, stop after 300 issues");
        runStream(0, 1, 1'b0, 300, 0);

        $display("[TB] reset at sample 50, then restart with step 0");
        runStream(1, 1, 1'b0, 0, 50);
        @(negedge clk);
        checkOutput("in_reset_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("post_reset_idle", busy, 0);
        runStream(1, 0, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
